// File: rtl/neuron_accumulator.sv
// Neuron accumulator: multiply-accumulates N_INPUTS Q8.8 input/weight pairs
// into a 40-bit accumulator, adds an optional Q16.16 bias on the first pair,
// then hands a saturated Q16.16 sum to a downstream activation stage. The
// block does not take new pairs until the activation stage reports done.
module neuron_accumulator #(
    parameter int N_INPUTS = 8,
    parameter int BIAS_EN  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_in,
    input  logic [15:0] w_in,
    input  logic [31:0] bias,
    input  logic        act_done,
    output logic [31:0] sum_out,
    output logic        start,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT_ACT = 2'd3
    } state_t;

    localparam logic [7:0] N_LAST = 8'(N_INPUTS);

    state_t             state_q;
    logic signed [39:0] acc_q;
    logic        [7:0]  cnt_q;
    logic        [31:0] sum_out_q;
    logic               start_q;

    logic signed [31:0] product;
    logic signed [39:0] product_ext;
    logic signed [39:0] bias_term;
    logic        [7:0]  cnt_d;
    logic        [31:0] sat_d;
    logic               accept;

    // Full-precision Q16.16 product, sign-extended into accumulator width.
    assign product     = $signed(x_in) * $signed(w_in);
    assign product_ext = {{8{product[31]}}, product};
    assign bias_term   = (BIAS_EN != 0) ? {{8{bias[31]}}, bias} : 40'sd0;
    assign cnt_d       = cnt_q + 8'd1;

    // Pairs are only taken while collecting; the result phase back-pressures.
    assign in_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);
    assign sum_out  = sum_out_q;
    assign start    = start_q;

    // Clamp the accumulator to 32 bits: in range iff bits 39..31 all agree.
    always_comb begin
        sat_d = acc_q[31:0];
        if (!((&acc_q[39:31]) || !(|acc_q[39:31]))) begin
            sat_d = acc_q[39] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Control FSM with accumulator, counter and registered start/sum outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_out_q <= '0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_q   <= product_ext + bias_term;
                        cnt_q   <= 8'd1;
                        state_q <= (N_INPUTS == 1) ? S_ISSUE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_q + product_ext;
                        cnt_q <= cnt_d;
                        if (cnt_d == N_LAST) begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // sum_out then stays put until the next evaluation issues.
                    sum_out_q <= sat_d;
                    start_q   <= 1'b1;
                    state_q   <= S_WAIT_ACT;
                end
                S_WAIT_ACT: begin
                    if (act_done) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: two instances (N_INPUTS=4 and N_INPUTS=1)
// share one stimulus stream; each is checked every cycle against a
// transaction-level model, plus literal expectations for key scenarios.
module tb_neuron_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] w_in = '0;
    logic [31:0] bias = '0;
    logic        act_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_eval = 0;

    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int N = (gi == 0) ? 4 : 1;
            logic        rdy, st, bsy;
            logic [31:0] so;

            neuron_accumulator #(.N_INPUTS(N), .BIAS_EN(1)) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .in_valid (in_valid),
                .in_ready (rdy),
                .x_in     (x_in),
                .w_in     (w_in),
                .bias     (bias),
                .act_done (act_done),
                .sum_out  (so),
                .start    (st),
                .busy     (bsy)
            );

            // Model: count of pairs in the current evaluation, running sum,
            // whether the evaluation is complete (waiting for release) and
            // whether its start pulse is still due on the next edge.
            int          m_cnt = 0;
            bit          m_full = 1'b0;
            bit          m_issue = 1'b0;
            longint      m_acc = 0;
            logic [31:0] e_sum = '0;
            bit          e_start = 1'b0;

            initial begin
                bit take;
                forever begin
                    @(posedge clk or negedge rst_n);
                    if (!rst_n) begin
                        m_cnt = 0; m_full = 0; m_issue = 0; m_acc = 0;
                        e_sum = '0; e_start = 0;
                    end else begin
                        take = in_valid && !m_full;
                        e_start = 0;
                        if (m_issue) begin
                            e_start = 1;
                            e_sum   = sat32(m_acc);
                            m_issue = 0;
                        end else if (m_full && act_done) begin
                            m_full = 0; m_cnt = 0; m_acc = 0;
                        end
                        if (take) begin
                            if (m_cnt == 0) m_acc = longint'($signed(bias));
                            m_acc += longint'($signed(x_in)) * longint'($signed(w_in));
                            m_cnt++;
                            if (m_cnt == N) begin
                                m_full = 1; m_issue = 1;
                            end
                        end
                    end
                end
            end

            // Every-cycle comparison on the falling edge.
            initial begin
                forever begin
                    @(negedge clk);
                    check1($sformatf("dut%0d_in_ready", gi), rdy, !m_full);
                    check1($sformatf("dut%0d_busy", gi), bsy, m_cnt > 0);
                    check1($sformatf("dut%0d_start", gi), st, e_start);
                    check32($sformatf("dut%0d_sum_out", gi), so, e_sum);
                end
            end
        end
    endgenerate

    // Present a pair, hold it until N=4 instance accepts, then optional gap
    // cycles with occasional spurious act_done (instance 0 is collecting).
    task automatic send_pair(input logic [15:0] x, input logic [15:0] w, input int gap);
        bit got = 0;
        x_in = x; w_in = w; in_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            got = g_dut[0].rdy;
            @(negedge clk); #1;
        end
        check1("accept_timeout", got, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < gap; k++) begin
            act_done = ($urandom_range(0, 3) == 0);
            @(negedge clk); #1;
        end
        act_done = 1'b0;
    endtask

    task automatic wait_start0();
        bit got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = g_dut[0].st;
        end
        check1("start0_timeout", got, 1'b1);
        n_eval++;
        $display("eval %0d: start seen, sum_out=%h", n_eval, g_dut[0].so);
        #1;
    endtask

    task automatic act_pulse();
        act_done = 1'b1;
        @(negedge clk); #1;
        act_done = 1'b0;
        check1("busy0_after_act", g_dut[0].bsy, 1'b0);
    endtask

    task automatic run_eval(input logic [31:0] b, input logic [63:0] xs, input logic [63:0] ws,
                            input int max_gap, input int act_delay,
                            input bit chk, input logic [31:0] exp);
        bias = b;
        for (int k = 0; k < 2; k++) begin
            act_done = ($urandom_range(0, 2) == 0);
            @(negedge clk); #1;
        end
        act_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_pair(xs[16*k +: 16], ws[16*k +: 16], (k == 3) ? 0 : $urandom_range(0, max_gap));
        end
        wait_start0();
        if (chk) check32("sum0_literal", g_dut[0].so, exp);
        for (int k = 0; k < act_delay; k++) begin
            @(negedge clk); #1;
        end
        act_pulse();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        check1("reset_ready0", g_dut[0].rdy, 1'b1);
        check1("reset_busy0", g_dut[0].bsy, 1'b0);
        check1("reset_start0", g_dut[0].st, 1'b0);
        check32("reset_sum0", g_dut[0].so, 32'h0);

        // Spurious act_done while idle.
        act_done = 1'b1;
        @(negedge clk); #1;
        act_done = 1'b0;
        check1("spurious_idle_busy0", g_dut[0].bsy, 1'b0);
        check1("spurious_idle_start0", g_dut[0].st, 1'b0);

        // Basic: 4 x (1.0*2.0) + 1.0 = 9.0, back-to-back pairs.
        run_eval(32'h0001_0000, {4{16'h0100}}, {4{16'h0200}}, 0, 3, 1'b1, 32'h0009_0000);
        // Saturation, both directions.
        run_eval(32'h0, {4{16'h7FFF}}, {4{16'h7FFF}}, 1, 1, 1'b1, 32'h7FFF_FFFF);
        run_eval(32'h0, {4{16'h8000}}, {4{16'h7FFF}}, 1, 1, 1'b1, 32'h8000_0000);

        // Single-input instance: -1.0 * 3.0 = -3.0, start one edge after accept.
        bias = 32'h0;
        send_pair(16'hFF00, 16'h0300, 0);
        check1("n1_ready_in_issue", g_dut[1].rdy, 1'b0);
        check1("n1_start_in_issue", g_dut[1].st, 1'b0);
        @(negedge clk);
        check1("n1_start", g_dut[1].st, 1'b1);
        check32("n1_sum", g_dut[1].so, 32'hFFFD_0000);
        #1;
        act_done = 1'b1;
        @(negedge clk); #1;
        act_done = 1'b0;
        check1("spurious_accum_busy0", g_dut[0].bsy, 1'b1);

        // Reset after 2 of 4 pairs: outputs return to reset values at once.
        send_pair(16'h0100, 16'h0100, 0);
        rst_n = 1'b0;
        #1;
        check32("midreset_sum0", g_dut[0].so, 32'h0);
        check1("midreset_busy0", g_dut[0].bsy, 1'b0);
        check1("midreset_ready0", g_dut[0].rdy, 1'b1);
        check1("midreset_start0", g_dut[0].st, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        // Fresh evaluation: 4 x (1.5*1.0) + 0.5 = 6.5.
        run_eval(32'h0000_8000, {4{16'h0180}}, {4{16'h0100}}, 2, 0, 1'b1, 32'h0006_8000);

        // Stall and handshake: gapped pairs, -2+2+1+6 + 3 = 10.0.
        bias = 32'h0003_0000;
        send_pair(16'h0200, 16'hFF00, 2);
        send_pair(16'h0080, 16'h0400, 3);
        send_pair(16'h0100, 16'h0100, 1);
        send_pair(16'h0300, 16'h0200, 0);
        wait_start0();
        check32("stall_sum0", g_dut[0].so, 32'h000A_0000);
        bias = 32'h0;
        x_in = 16'h0100; w_in = 16'h0100; in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check1("stall_ready0", g_dut[0].rdy, 1'b0);
            check32("stall_hold_sum0", g_dut[0].so, 32'h000A_0000);
            @(negedge clk); #1;
        end
        act_done = 1'b1;
        @(negedge clk);
        check1("release_ready0", g_dut[0].rdy, 1'b1);
        check1("release_busy0", g_dut[0].bsy, 1'b0);
        #1 act_done = 1'b0;
        @(negedge clk);
        check1("next_accept_busy0", g_dut[0].bsy, 1'b1);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 3; k++) send_pair(16'h0100, 16'h0100, (k == 2) ? 0 : 1);
        wait_start0();
        check32("after_stall_sum0", g_dut[0].so, 32'h0004_0000);
        act_pulse();

        // Randomized evaluations, checked by the model.
        for (int r = 0; r < 25; r++) begin
            logic [63:0] xs, ws;
            logic [31:0] b;
            xs = {$urandom, $urandom};
            ws = {$urandom, $urandom};
            b  = (r % 5 == 0) ? 32'h7FFF_0000 : $urandom;
            run_eval(b, xs, ws, 3, $urandom_range(0, 6), 1'b0, 32'h0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 Parameter N_INPUTS, default 8, number of weighted inputs summed per neuron evaluation (legal range 1-255).
REQ-002 Parameter BIAS_EN, default 1, when 1 the bias input is added to each sum.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  x_in/w_in pair valid this cycle.
REQ-006 in_ready  output  1  block accepts a pair this cycle.
REQ-007 x_in  input  16  signed Q8.8 neuron input.
REQ-008 w_in  input  16  signed Q8.8 weight.
REQ-009 bias  input  32  signed Q16.16 bias, sampled at accept of the first pair.
REQ-010 act_done  input  1  end pulse from the downstream activation stage.
REQ-011 sum_out  output  32  signed Q16.16 saturated weighted sum, the x operand of the activation stage.
REQ-012 start  output  1  one-cycle pulse launching the activation stage.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, ACCUM, ISSUE, WAIT_ACT. Encoding is free.
REQ-015 A pair is accepted on a clock edge where in_valid and in_ready are both 1.
REQ-016 in_ready is 1 in IDLE and ACCUM, and 0 in ISSUE and WAIT_ACT.
REQ-017 IDLE: on accept, load acc = sext40(x_in*w_in) + (BIAS_EN ? sext40(bias) : 0), set cnt=1, go to ACCUM. If N_INPUTS==1, go to ISSUE instead.
REQ-018 ACCUM: on accept, acc += sext40(x_in*w_in) and cnt += 1. When the incremented cnt equals N_INPUTS, go to ISSUE.
REQ-019 ACCUM with in_valid low: hold acc, cnt and state. There is no timeout.
REQ-020 The product x_in*w_in is a full 32-bit signed Q16.16 value. The accumulator is 40-bit signed and cannot overflow for N_INPUTS<=255.
REQ-021 ISSUE: register sum_out = sat32(acc), assert start for exactly this one cycle, then go to WAIT_ACT.
REQ-022 sat32 clamps to 0x7FFFFFFF if acc > 2^31-1. It clamps to 0x80000000 if acc < -2^31. Otherwise it passes acc[31:0].
REQ-023 sum_out is held stable from the ISSUE cycle until the next ISSUE, because the downstream stage samples it over multiple cycles.
REQ-024 WAIT_ACT: on act_done==1, go to IDLE and clear acc and cnt.
REQ-025 act_done in any other state is ignored.
REQ-026 Latency: start rises on the clock edge one cycle after the edge that accepts the N_INPUTS-th pair.
REQ-027 Throughput: the next evaluation can be accepted on the cycle after act_done is seen in WAIT_ACT.
REQ-028 Back-to-back pairs on consecutive cycles are accepted without bubbles in IDLE and ACCUM.
REQ-029 in_valid during ISSUE or WAIT_ACT is not accepted. The pair stays pending at the source.
REQ-030 start is 0 in every state except ISSUE.
REQ-031 start and sum_out are registered outputs.

Reset
REQ-032 rst_n low asynchronously forces: state=IDLE, acc=0, cnt=0, sum_out=0, start=0, busy=0, in_ready=1 (in_ready=1 follows from state=IDLE; it is not a flop reset).
REQ-033 Reset asserted mid-ACCUM or mid-WAIT_ACT discards the partial sum; no start is emitted.
REQ-034 After rst_n rises, the first accept occurs no earlier than the first rising clk edge.

Verification
REQ-035 Basic: N_INPUTS=4, BIAS_EN=1, bias=0x00010000, four pairs x=0x0100, w=0x0200 -> one start pulse, sum_out=0x00090000, busy low after act_done.
REQ-036 Saturation: N_INPUTS=4, bias=0, four pairs x=0x7FFF, w=0x7FFF -> sum_out=0x7FFFFFFF. Same test with x=0x8000, w=0x7FFF -> sum_out=0x80000000.
REQ-037 Stall and handshake: in_valid gapped between pairs, act_done delayed 20 cycles -> in_ready=0 and no accept while waiting. The next evaluation starts the cycle after act_done. sum_out is stable throughout the wait.
REQ-038 N_INPUTS=1: single pair x=0xFF00 (-1.0), w=0x0300 (3.0), bias=0 -> start one cycle after accept, sum_out=0xFFFD0000.
REQ-039 Reset mid-operation: rst_n pulsed low after 2 of 4 pairs -> outputs at reset values immediately. Then a fresh 4-pair evaluation yields the correct sum with no stale contribution.
REQ-040 Spurious act_done pulsed in IDLE and ACCUM -> no state change, no extra start.
